// File: rtl/seg7_capture.sv
// seg7_capture: samples a scanned, active-low 4-digit 7-segment bus and
// rebuilds the displayed number as BCD and binary.
module seg7_capture #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  led7segk,
    input  logic [3:0]  led7sega,
    output logic [13:0] num,
    output logic [15:0] bcd,
    output logic        valid,
    output logic        seg_err,
    output logic        seq_err,
    output logic        stale
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPT,
        CONV
    } state_t;

    state_t        state, state_n;
    logic [10:0]   sync1, sync2, prev;
    logic [SW-1:0] stab;
    logic [TW-1:0] idle_cnt;
    logic [1:0]    exp_q, exp_n;
    logic [1:0]    cidx, cidx_n;
    logic [15:0]   digs, digs_n;
    logic [13:0]   acc, acc_n, acc_step;
    logic [3:0]    cur_d;
    logic [3:0]    an;
    logic [6:0]    cath;
    logic [1:0]    pos;
    logic          one_low;
    logic [3:0]    dval;
    logic          dok;
    logic          same;
    logic          ev;
    logic          tmo;
    logic          conv_done;

    assign an   = sync2[10:7];
    assign cath = sync2[6:0];
    assign same = (sync2 == prev);
    assign ev   = same && (stab == SW'(SETTLE - 1)) && one_low;
    assign tmo  = !ev && (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {led7sega, led7segk};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // stab counts consecutive cycles of an unchanged synchronized bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab <= '0;
        end else if (!same) begin
            stab <= '0;
        end else if (stab != SW'(SETTLE)) begin
            stab <= stab + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (ev) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TW'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_comb begin
        one_low = 1'b1;
        pos     = 2'd0;
        case (an)
            4'b0111: pos = 2'd3;
            4'b1011: pos = 2'd2;
            4'b1101: pos = 2'd1;
            4'b1110: pos = 2'd0;
            default: one_low = 1'b0;
        endcase
    end

    always_comb begin
        dok  = 1'b1;
        dval = 4'd0;
        case (cath)
            7'b1000000: dval = 4'd0;
            7'b1111001: dval = 4'd1;
            7'b0100100: dval = 4'd2;
            7'b0110000: dval = 4'd3;
            7'b0011001: dval = 4'd4;
            7'b0010010: dval = 4'd5;
            7'b0000010: dval = 4'd6;
            7'b1111000: dval = 4'd7;
            7'b0000000: dval = 4'd8;
            7'b0010000: dval = 4'd9;
            default:    dok  = 1'b0;
        endcase
    end

    always_comb begin
        cur_d = 4'd0;
        case (cidx)
            2'd3: cur_d = digs[15:12];
            2'd2: cur_d = digs[11:8];
            2'd1: cur_d = digs[7:4];
            2'd0: cur_d = digs[3:0];
            default: cur_d = 4'd0;
        endcase
    end

    assign acc_step = (acc << 3) + (acc << 1) + {10'd0, cur_d};

    always_comb begin
        state_n   = state;
        exp_n     = exp_q;
        cidx_n    = cidx;
        digs_n    = digs;
        acc_n     = acc;
        seg_err   = 1'b0;
        seq_err   = 1'b0;
        conv_done = 1'b0;
        case (state)
            IDLE: begin
                if (ev) begin
                    if (!dok) begin
                        seg_err = 1'b1;
                    end else if (pos == 2'd3) begin
                        digs_n[15:12] = dval;
                        exp_n         = 2'd2;
                        state_n       = CAPT;
                    end
                end
            end
            CAPT: begin
                if (ev) begin
                    if (!dok) begin
                        seg_err = 1'b1;
                        state_n = IDLE;
                    end else if (pos == exp_q) begin
                        digs_n[{pos, 2'b00} +: 4] = dval;
                        if (pos == 2'd0) begin
                            state_n = CONV;
                            cidx_n  = 2'd3;
                            acc_n   = '0;
                        end else begin
                            exp_n = exp_q - 1'b1;
                        end
                    end else if (pos == 2'd3) begin
                        seq_err       = 1'b1;
                        digs_n[15:12] = dval;
                        exp_n         = 2'd2;
                    end else begin
                        seq_err = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            CONV: begin
                acc_n  = acc_step;
                cidx_n = cidx - 1'b1;
                if (cidx == 2'd0) begin
                    conv_done = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (tmo) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            exp_q <= 2'd0;
            cidx  <= 2'd0;
            digs  <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            exp_q <= exp_n;
            cidx  <= cidx_n;
            digs  <= digs_n;
            acc   <= acc_n;
        end
    end

    // digs is stable through CONV, so it is the frame's BCD image
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num   <= '0;
            bcd   <= '0;
            valid <= 1'b0;
            stale <= 1'b1;
        end else begin
            valid <= conv_done;
            if (conv_done) begin
                num   <= acc_step;
                bcd   <= digs;
                stale <= 1'b0;
            end else if (tmo) begin
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed and randomized scans of the display bus,
// compared against a frame-level model of the capture rules.
module tb_seg7_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 3000;
    localparam int LAT     = 2 + SETTLE + 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  led7segk = 7'h7F;
    logic [3:0]  led7sega = 4'hF;
    logic [13:0] num;
    logic [15:0] bcd;
    logic        valid;
    logic        seg_err;
    logic        seq_err;
    logic        stale;

    seg7_capture #(
        .SETTLE (SETTLE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .led7segk(led7segk),
        .led7sega(led7sega),
        .num     (num),
        .bcd     (bcd),
        .valid   (valid),
        .seg_err (seg_err),
        .seq_err (seq_err),
        .stale   (stale)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int obs_valid = 0;
    int obs_seg = 0;
    int obs_seq = 0;
    int last_valid_cyc = 0;
    always @(negedge clk) begin
        if (valid) begin
            obs_valid++;
            last_valid_cyc = cyc;
        end
        if (seg_err) obs_seg++;
        if (seq_err) obs_seq++;
    end

    logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // model: digits gathered so far, plus expected output state
    int          q[$];
    logic [10:0] cur_pat = 11'h7FF;
    int          cur_dwell = 1000;
    int          m_valid = 0;
    int          m_seg = 0;
    int          m_seq = 0;
    int          m_num = 0;
    logic        m_stale = 1'b1;
    int          t_d0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_event(input int p, input logic [6:0] code);
        int d;
        d = -1;
        for (int i = 0; i < 10; i++) if (lut[i] == code) d = i;
        if (d < 0) begin
            m_seg++;
            q.delete();
        end else if (q.size() == 0) begin
            if (p == 3) q.push_back(d);
        end else if (p == 3 - q.size()) begin
            q.push_back(d);
            if (q.size() == 4) begin
                m_num = q[0] * 1000 + q[1] * 100 + q[2] * 10 + q[3];
                m_stale = 1'b0;
                m_valid++;
                q.delete();
            end
        end else begin
            m_seq++;
            q.delete();
            if (p == 3) q.push_back(d);
        end
    endtask

    task automatic finalize();
        int z;
        int p;
        z = 0;
        p = 0;
        for (int i = 0; i < 4; i++) begin
            if (!cur_pat[7+i]) begin
                z++;
                p = i;
            end
        end
        if (cur_dwell >= SETTLE + 1 && z == 1) model_event(p, cur_pat[6:0]);
    endtask

    // called just after a falling edge; holds the pins for dw cycles
    task automatic step(input logic [3:0] an, input logic [6:0] k, input int dw);
        if ({an, k} != cur_pat) begin
            finalize();
            cur_pat = {an, k};
            cur_dwell = 0;
        end
        led7sega = an;
        led7segk = k;
        repeat (dw) @(negedge clk);
        cur_dwell += dw;
    endtask

    task automatic flush();
        step(4'hF, 7'h7F, 20);
    endtask

    task automatic send_frame(input int n, input int dw);
        step(4'b0111, lut[(n / 1000) % 10], dw);
        step(4'b1011, lut[(n / 100) % 10], dw);
        step(4'b1101, lut[(n / 10) % 10], dw);
        t_d0 = cyc;
        step(4'b1110, lut[n % 10], dw);
    endtask

    task automatic check_all(input string tag);
        logic [15:0] eb;
        eb = 16'(((m_num / 1000) % 10) << 12 | ((m_num / 100) % 10) << 8 |
                 ((m_num / 10) % 10) << 4 | (m_num % 10));
        chk({tag, ".num"}, 32'(num), 32'(m_num));
        chk({tag, ".bcd"}, 32'(bcd), 32'(eb));
        chk({tag, ".stale"}, 32'(stale), 32'(m_stale));
        chk({tag, ".nvalid"}, obs_valid, m_valid);
        chk({tag, ".nseg"}, obs_seg, m_seg);
        chk({tag, ".nseq"}, obs_seq, m_seq);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] an;
        int mode;
        int p;
        @(negedge clk);
        chk("rst.num", 32'(num), 0);
        chk("rst.bcd", 32'(bcd), 0);
        chk("rst.valid", 32'(valid), 0);
        chk("rst.stale", 32'(stale), 1);
        chk("rst.err", 32'({seg_err, seq_err}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        step(4'hF, 7'h7F, 1000);
        check_all("t1");

        send_frame(1234, 100);
        flush();
        check_all("t2a");
        chk("t2.latency", 32'(last_valid_cyc - t_d0), LAT);
        send_frame(1234, 100);
        flush();
        check_all("t2b");

        send_frame(9999, 100);
        flush();
        check_all("t3a");
        chk("t3.hex", 32'(num), 32'h270F);
        send_frame(0, 100);
        flush();
        check_all("t3b");

        send_frame(5678, 3);
        flush();
        check_all("t4");
        send_frame(3456, SETTLE + 1);
        flush();
        check_all("t4edge");

        step(4'b0111, lut[4], 100);
        step(4'b1011, 7'h7F, 100);
        flush();
        check_all("t5a");
        send_frame(42, 100);
        flush();
        check_all("t5b");

        step(4'b0111, lut[1], 100);
        step(4'b1101, lut[2], 100);
        step(4'b1110, lut[3], 100);
        flush();
        check_all("t6a");
        step(4'b0111, lut[5], 100);
        step(4'b1011, lut[6], 100);
        step(4'b0111, lut[7], 100);
        step(4'b1011, lut[8], 100);
        step(4'b1101, lut[9], 100);
        step(4'b1110, lut[0], 100);
        flush();
        check_all("t6b");

        send_frame(4321, 100);
        step(4'hF, 7'h7F, TIMEOUT - 100);
        check_all("t7pre");
        step(4'hF, 7'h7F, 200);
        m_stale = 1'b1;
        q.delete();
        check_all("t7tmo");

        send_frame(1357, 100);
        step(4'b0111, lut[8], 100);
        step(4'b1011, lut[6], 100);
        step(4'hF, 7'h7F, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("t7rst.num", 32'(num), 0);
        chk("t7rst.stale", 32'(stale), 1);
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_num = 0;
        m_stale = 1'b1;
        cur_pat = 11'h7FF;
        cur_dwell = 0;
        check_all("t7rst");
        send_frame(2468, 100);
        flush();
        check_all("t7post");

        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 9));
            if (mode <= 5) begin
                step(4'b0111, lut[$urandom_range(0, 9)], int'($urandom_range(SETTLE + 1, 30)));
                step(4'b1011, lut[$urandom_range(0, 9)], int'($urandom_range(SETTLE + 1, 30)));
                step(4'b1101, lut[$urandom_range(0, 9)], int'($urandom_range(SETTLE + 1, 30)));
                step(4'b1110, lut[$urandom_range(0, 9)], int'($urandom_range(SETTLE + 1, 30)));
            end else if (mode == 6) begin
                for (int j = 0; j < 3; j++) begin
                    an = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 1) == 1)
                        step(an, lut[$urandom_range(0, 9)], int'($urandom_range(2, 30)));
                    else
                        step(an, 7'($urandom_range(0, 127)), int'($urandom_range(2, 30)));
                end
            end else if (mode == 7) begin
                step(4'b0111, lut[$urandom_range(0, 9)], int'($urandom_range(2, SETTLE)));
                step(4'b1011, lut[$urandom_range(0, 9)], int'($urandom_range(2, SETTLE)));
                step(4'b1101, lut[$urandom_range(0, 9)], int'($urandom_range(2, SETTLE)));
                step(4'b1110, lut[$urandom_range(0, 9)], int'($urandom_range(2, SETTLE)));
            end else begin
                for (int j = 0; j < 4; j++) begin
                    p = int'($urandom_range(0, 3));
                    an = 4'hF;
                    an[p] = 1'b0;
                    step(an, lut[$urandom_range(0, 9)], int'($urandom_range(SETTLE + 1, 30)));
                end
            end
            flush();
            check_all($sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
